// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the uart_tx arbiter.
// The master side belongs to the byte-stream sources, the slave side to the arbiter.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   byte_ack;
   logic [NREQ-1:0]   byte_done;

   modport master (
      output req, req_data, req_last,
      input  grant, byte_ack, byte_done
   );

   modport slave (
      input  req, req_data, req_last,
      output grant, byte_ack, byte_done
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin sharing of one uart_tx between NREQ byte streams,
// with a per-byte watchdog on tx_done_tick.
module uart_tx_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 100000000,
   parameter int CW      = 30
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_arbiter_if.slave rq,
   output logic             timeout_err,
   output logic             busy,
   output logic             tx_start,
   output logic [7:0]       din,
   input  logic             tx_done_tick
);

   localparam int IW = (NREQ > 2) ? 2 : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      HOLD
   } state_t;

   state_t          state;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   last_grant;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   cand;
   logic [IW:0]     sum;
   logic [NREQ-1:0] pick_oh;
   logic            last_flag;
   logic [CW-1:0]   cnt;

   // Walk downward so the nearest set bit after last_grant is written last.
   always_comb begin
      pick = last_grant;
      sum  = '0;
      cand = '0;
      for (int k = NREQ; k >= 1; k--) begin
         sum = {1'b0, last_grant} + (IW+1)'(k);
         if (sum >= (IW+1)'(NREQ))
            sum = sum - (IW+1)'(NREQ);
         cand = sum[IW-1:0];
         if (rq.req[cand])
            pick = cand;
      end
   end

   assign pick_oh = NREQ'(1) << pick;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= '0;
         last_grant  <= IW'(NREQ-1);
         last_flag   <= 1'b0;
         cnt         <= '0;
         rq.grant    <= '0;
         rq.byte_ack <= '0;
         rq.byte_done <= '0;
         timeout_err <= 1'b0;
         tx_start    <= 1'b0;
         busy        <= 1'b0;
         din         <= '0;
      end else begin
         rq.byte_ack  <= '0;
         rq.byte_done <= '0;
         timeout_err  <= 1'b0;
         tx_start     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|rq.req) begin
                  owner    <= pick;
                  rq.grant <= pick_oh;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               din         <= rq.req_data[{owner, 3'b000} +: 8];
               last_flag   <= rq.req_last[owner];
               rq.byte_ack <= rq.grant;
               state       <= START;
            end
            START: begin
               tx_start <= 1'b1;
               cnt      <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               // A done tick on the timeout cycle still counts as success.
               if (tx_done_tick) begin
                  rq.byte_done <= rq.grant;
                  if (last_flag) begin
                     rq.grant   <= '0;
                     last_grant <= owner;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     state <= HOLD;
                  end
               end else if (cnt == CW'(TIMEOUT-1)) begin
                  timeout_err <= 1'b1;
                  rq.grant    <= '0;
                  last_grant  <= owner;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (rq.req[owner]) begin
                  state <= LOAD;
               end else begin
                  rq.grant   <= '0;
                  last_grant <= owner;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two requesters, a delayed-tick uart_tx
// model, and a monitor that logs every started byte.
module tb_uart_tx_arbiter;

   localparam int NREQ = 2;
   localparam int DLY  = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       timeout_err;
   logic       busy;
   logic       tx_start;
   logic [7:0] din;
   logic       tx_done_tick = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NREQ(NREQ)) ifc ();

   uart_tx_arbiter #(
      .NREQ(NREQ),
      .TIMEOUT(20),
      .CW(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rq(ifc),
      .timeout_err(timeout_err),
      .busy(busy),
      .tx_start(tx_start),
      .din(din),
      .tx_done_tick(tx_done_tick)
   );

   int n_err = 0;
   int n_chk = 0;
   int cyc = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] h0, h1;

   logic [7:0] sent_d[$];
   logic [1:0] sent_g[$];
   int         ack_gap[$];
   int         done_gap[$];
   int ack_cyc = 0, done_cyc = 0, start_cyc = 0, to_cyc = 0;
   int ack_n0 = 0, done_n0 = 0, ack_n1 = 0, done_n1 = 0;
   int to_n = 0, bad_ho = 0;
   logic [1:0] prev_g = '0;
   logic [1:0] grant_at_to = '1;
   logic       busy_at_to = 1'b1;
   bit         model_en = 1'b1;
   int         pend = 0;

   // Requesters: present queue head, pop it on byte_ack.
   always @(negedge clk) begin
      if (ifc.byte_ack[0] && q0.size() > 0) void'(q0.pop_front());
      if (ifc.byte_ack[1] && q1.size() > 0) void'(q1.pop_front());
      h0 = (q0.size() > 0) ? q0[0] : 9'h000;
      h1 = (q1.size() > 0) ? q1[0] : 9'h000;
      ifc.req      = {q1.size() > 0, q0.size() > 0};
      ifc.req_data = {h1[7:0], h0[7:0]};
      ifc.req_last = {h1[8], h0[8]};
   end

   // uart_tx stand-in: one-cycle done tick DLY cycles after tx_start.
   always @(negedge clk) begin
      tx_done_tick = 1'b0;
      if (!rst_n || ifc.grant == '0) begin
         pend = 0;
      end else if (pend > 0) begin
         pend--;
         if (pend == 0 && model_en) tx_done_tick = 1'b1;
      end else if (tx_start) begin
         pend = DLY;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (tx_start) begin
            sent_d.push_back(din);
            sent_g.push_back(ifc.grant);
            ack_gap.push_back(cyc - ack_cyc);
            done_gap.push_back(cyc - done_cyc);
            start_cyc = cyc;
         end
         if (|ifc.byte_ack) ack_cyc = cyc;
         if (|ifc.byte_done) done_cyc = cyc;
         if (ifc.byte_ack[0]) ack_n0++;
         if (ifc.byte_ack[1]) ack_n1++;
         if (ifc.byte_done[0]) done_n0++;
         if (ifc.byte_done[1]) done_n1++;
         if (timeout_err) begin
            to_n++;
            to_cyc = cyc;
            grant_at_to = ifc.grant;
            busy_at_to = busy;
         end
         if (prev_g != '0 && ifc.grant != '0 && prev_g != ifc.grant)
            bad_ho++;
         prev_g = ifc.grant;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_sent(input int n, input string tag);
      int k;
      k = 0;
      while (!(sent_d.size() >= n && !busy && q0.size() == 0 &&
               q1.size() == 0) && k < 1000) begin
         tick();
         k++;
      end
      chk({tag, "_in_time"}, 32'(k < 1000), 32'd1);
   endtask

   task automatic chk_out_zero(input string tag);
      chk(tag, 32'({ifc.grant, ifc.byte_ack, ifc.byte_done,
                    timeout_err, busy, tx_start, din}), 32'd0);
   endtask

   int b, a0, d0, t0, k;

   initial begin
      q0.push_back(9'h131);
      q1.push_back(9'h132);
      tick(); tick(); tick();
      chk_out_zero("reset_outputs");
      rst_n = 1'b1;

      // Simultaneous requests from reset: requester 0 first.
      wait_sent(2, "sim1");
      chk("sim1_d0", 32'(sent_d[0]), 32'h31);
      chk("sim1_g0", 32'(sent_g[0]), 32'h1);
      chk("sim1_d1", 32'(sent_d[1]), 32'h32);
      chk("sim1_g1", 32'(sent_g[1]), 32'h2);
      chk("ack_to_start", 32'(ack_gap[0]), 32'd1);
      chk("handover_gap", 32'(bad_ho), 32'd0);

      // Single three-byte packet on requester 0.
      b = sent_d.size(); a0 = ack_n0; d0 = done_n0;
      q0.push_back(9'h041);
      q0.push_back(9'h042);
      q0.push_back(9'h143);
      wait_sent(b + 3, "pkt");
      chk("pkt_d0", 32'(sent_d[b]), 32'h41);
      chk("pkt_d1", 32'(sent_d[b+1]), 32'h42);
      chk("pkt_d2", 32'(sent_d[b+2]), 32'h43);
      chk("pkt_g2", 32'(sent_g[b+2]), 32'h1);
      chk("pkt_acks", 32'(ack_n0 - a0), 32'd3);
      chk("pkt_dones", 32'(done_n0 - d0), 32'd3);
      chk("done_to_start", 32'(done_gap[b+1]), 32'd3);
      chk("pkt_grant_free", 32'(ifc.grant), 32'h0);

      // Second simultaneous round after requester 0 owned last.
      b = sent_d.size();
      q0.push_back(9'h133);
      q1.push_back(9'h134);
      wait_sent(b + 2, "sim2");
      chk("sim2_d0", 32'(sent_d[b]), 32'h34);
      chk("sim2_g0", 32'(sent_g[b]), 32'h2);
      chk("sim2_d1", 32'(sent_d[b+1]), 32'h33);
      chk("sim2_g1", 32'(sent_g[b+1]), 32'h1);

      // Packet lock: requester 1 arrives mid-packet.
      b = sent_d.size();
      q0.push_back(9'h051);
      q0.push_back(9'h052);
      q0.push_back(9'h053);
      q0.push_back(9'h154);
      k = 0;
      while (sent_d.size() < b + 1 && k < 500) begin
         tick();
         k++;
      end
      chk("lock_first_byte", 32'(k < 500), 32'd1);
      q1.push_back(9'h160);
      wait_sent(b + 5, "lock");
      chk("lock_d1", 32'(sent_d[b+1]), 32'h52);
      chk("lock_d3", 32'(sent_d[b+3]), 32'h54);
      chk("lock_g3", 32'(sent_g[b+3]), 32'h1);
      chk("lock_d4", 32'(sent_d[b+4]), 32'h60);
      chk("lock_g4", 32'(sent_g[b+4]), 32'h2);
      chk("lock_handover", 32'(bad_ho), 32'd0);

      // Owner drops req in HOLD: silent abort, requester 1 next.
      b = sent_d.size(); t0 = to_n; d0 = done_n0;
      q0.push_back(9'h070);
      q1.push_back(9'h171);
      wait_sent(b + 2, "abort");
      chk("abort_d0", 32'(sent_d[b]), 32'h70);
      chk("abort_d1", 32'(sent_d[b+1]), 32'h71);
      chk("abort_g1", 32'(sent_g[b+1]), 32'h2);
      chk("abort_no_err", 32'(to_n - t0), 32'd0);
      chk("abort_done0", 32'(done_n0 - d0), 32'd1);

      // Watchdog with no done tick.
      model_en = 1'b0;
      b = sent_d.size(); t0 = to_n; d0 = done_n0;
      q0.push_back(9'h180);
      wait_sent(b + 1, "wdog");
      chk("wdog_pulses", 32'(to_n - t0), 32'd1);
      chk("wdog_latency", 32'(to_cyc - start_cyc), 32'd20);
      chk("wdog_grant", 32'(grant_at_to), 32'h0);
      chk("wdog_busy", 32'(busy_at_to), 32'h0);
      chk("wdog_no_done", 32'(done_n0 - d0), 32'd0);
      tick();
      chk("wdog_single", 32'(timeout_err), 32'd0);
      model_en = 1'b1;

      // Reset during WAIT, then requester 0 regains first priority.
      b = sent_d.size();
      q0.push_back(9'h190);
      k = 0;
      while (sent_d.size() < b + 1 && k < 500) begin
         tick();
         k++;
      end
      chk("rst_first_byte", 32'(k < 500), 32'd1);
      tick(); tick(); tick();
      chk("rst_in_wait", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      chk_out_zero("rst_outputs");
      rst_n = 1'b1;
      q0.push_back(9'h191);
      q1.push_back(9'h192);
      wait_sent(b + 3, "rst");
      chk("rst_d0", 32'(sent_d[b+1]), 32'h91);
      chk("rst_g0", 32'(sent_g[b+1]), 32'h1);
      chk("rst_d1", 32'(sent_d[b+2]), 32'h92);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
